// File: rtl/alarm_timer.sv
`default_nettype none
// ============================================================================
// alarm_timer : countdown timer with 1 Hz divider and programmable durations
// Revision    : 1.0
// ============================================================================
module alarm_timer #(
   parameter int unsigned CLK_HZ              = 27000000,
   parameter int unsigned T_ARM_DEFAULT       = 6,
   parameter int unsigned T_DRIVER_DEFAULT    = 8,
   parameter int unsigned T_PASSENGER_DEFAULT = 15,
   parameter int unsigned T_ALARM_DEFAULT     = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_timer,
   input  logic [1:0] interval,
   input  logic       prog_sync,
   input  logic [1:0] time_param_sel,
   input  logic [3:0] time_value,
   output logic       expired,
   output logic       busy,
   output logic [3:0] remaining,
   output logic       one_hz_enable
);

   localparam int unsigned DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] divider;
   logic [3:0]       time_param [4];
   logic [3:0]       selected;

   // The start reads the stored value from before any same-cycle write.
   assign selected      = time_param[interval];
   assign one_hz_enable = (divider == DIV_MAX);

   always_ff @(posedge clock) begin
      if (reset) begin
         time_param[0] <= 4'(T_ARM_DEFAULT);
         time_param[1] <= 4'(T_DRIVER_DEFAULT);
         time_param[2] <= 4'(T_PASSENGER_DEFAULT);
         time_param[3] <= 4'(T_ALARM_DEFAULT);
      end else if (prog_sync) begin
         time_param[time_param_sel] <= time_value;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         divider   <= '0;
         remaining <= 4'd0;
         busy      <= 1'b0;
         expired   <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (one_hz_enable) begin
            divider <= '0;
         end else begin
            divider <= divider + DIV_W'(1);
         end

         // A start always wins, including over the final tick of a countdown.
         if (start_timer) begin
            divider <= '0;
            if (selected != 4'd0) begin
               state     <= COUNT;
               busy      <= 1'b1;
               remaining <= selected;
            end else begin
               state     <= IDLE;
               busy      <= 1'b0;
               remaining <= 4'd0;
               expired   <= 1'b1;
            end
         end else if (state == COUNT && one_hz_enable) begin
            if (remaining <= 4'd1) begin
               state     <= IDLE;
               busy      <= 1'b0;
               remaining <= 4'd0;
               expired   <= 1'b1;
            end else begin
               remaining <= remaining - 4'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/alarm_timer.md
# alarm_timer

Countdown timer serving the anti-theft alarm controller's timer handshake. The controller issues a one-cycle `start_timer` with an interval selector. This block loads the matching programmable duration in seconds and counts it down against an internal 1 Hz enable. It returns a one-cycle `expired` pulse, which the controller consumes as its `timer_status` input. It also holds the four user-programmable time parameters and exports the 1 Hz enable for other blocks, such as the siren and status LED.

## Interface
- `CLK_HZ`, default 27000000: clock cycles per second. The bench uses small values.
- `T_ARM_DEFAULT`, default 6: arm-delay seconds after reset.
- `T_DRIVER_DEFAULT`, default 8: driver-door delay seconds after reset.
- `T_PASSENGER_DEFAULT`, default 15: passenger-door delay seconds after reset.
- `T_ALARM_DEFAULT`, default 10: siren-on seconds after reset.

Ports (reset is synchronous and active-high; the clock is `clock`):
- `clock` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `start_timer` input 1: one-cycle request to (re)start the countdown.
- `interval` input 2: duration select. 0 = arm, 1 = driver, 2 = passenger, 3 = alarm.
- `prog_sync` input 1: one-cycle write strobe for a time parameter.
- `time_param_sel` input 2: which parameter to write. Encoding matches `interval`.
- `time_value` input 4: seconds to write, 0–15.
- `expired` output 1: one-cycle pulse when the countdown reaches zero.
- `busy` output 1: high while a countdown is running.
- `remaining` output 4: seconds left in the current countdown. 0 when idle.
- `one_hz_enable` output 1: one-cycle pulse once every `CLK_HZ` cycles.

## Operation
**Parameter storage**
- Four 4-bit registers hold the time parameters.
- When `prog_sync` is high, `time_value` is written to the register chosen by `time_param_sel`.

**Divider**
- The divider is a counter running 0..`CLK_HZ`-1 that wraps to 0.
- `one_hz_enable` = (divider == `CLK_HZ`-1), decoded combinationally from the register.
- The divider free-runs while idle.
- It is cleared to 0 on any accepted `start_timer`, so the first second is always a full `CLK_HZ` cycles.

**States**
- IDLE:
  - `busy`=0, `remaining`=0.
  - On `start_timer`, with selected value V:
    - If V>0: `remaining`←V and go to COUNT.
    - If V=0: `expired`←1 at that edge and stay in IDLE.
- COUNT:
  - `busy`=1.
  - On each `one_hz_enable`, `remaining`←`remaining`-1.
  - When `remaining`=1 and `one_hz_enable` is high: `remaining`←0, `expired`←1, go to IDLE.

**Restart**
- `start_timer` in COUNT reloads from the newly selected interval and clears the divider.
- No `expired` is produced for the abandoned countdown.
- If `start_timer` and the final `one_hz_enable` coincide, the restart wins: no `expired`, and the timer is reloaded.

**Write and start together**
- If `prog_sync` and `start_timer` occur in the same cycle, the start loads the value stored before that edge.
- The new value applies to later starts only.

**Programming during a countdown**
- Writes never alter `remaining` in flight.

**Arithmetic**
- `remaining` never underflows.
- Decrement is applied only when `remaining` ≥ 1.

## Timing
**Reset**
- Parameters return to their `*_DEFAULT` values.
- Divider=0, state=IDLE, `remaining`=0, `busy`=0, `expired`=0.
- `one_hz_enable`=0, valid for `CLK_HZ` > 1.
- Reset overrides a simultaneous `start_timer` or `prog_sync`.
- Reset during COUNT aborts the countdown with no `expired`.

**Start response**
- `start_timer` is sampled at edge t.
- `busy` and `remaining`=V are visible after edge t.
- `expired` is high for exactly one cycle, V·`CLK_HZ` cycles after edge t.
- `busy` falls in the same cycle that `expired` rises.

**V=0**
- `expired` is high in the cycle after edge t.
- `busy` is never asserted.

**Pulse width**
- `expired` and `one_hz_enable` are always exactly one cycle wide.

**Write latency**
- A write takes effect one cycle after the `prog_sync` edge, i.e. at the next start.

## Test plan
Unless stated otherwise, tests use `CLK_HZ`=4.

- **Reset defaults:** pulse `reset`, then start `interval`=0. Required: `remaining`=6, `busy`=1, and `expired` pulses exactly 24 cycles after the start edge. Without a restart, `remaining` steps 6→0.
- **Program then start:** write `time_param_sel`=2 with `time_value`=3, then start `interval`=2. Required: `expired` at start+12 cycles, width 1. No `expired` at any other time.
- **Zero interval:** program the alarm parameter to 0, then start `interval`=3. Required: `expired` high in the next cycle only, and `busy` stays 0.
- **Restart mid-count:** start driver (8 s) and, 10 cycles later, start arm (6 s). Required: a single `expired`, 24 cycles after the second start.
- **Reset mid-count:** start passenger, then assert `reset` 5 cycles later. Required: `busy`=0, `remaining`=0, no `expired` ever. The passenger parameter reads back as 15 on the next start.
- **Write/start collision:** `prog_sync` (sel 0, value 2) in the same cycle as start `interval`=0. Required: this countdown uses 6 s, and the next arm start uses 2 s (`expired` 8 cycles after it).
